// File: rtl/sync_fifo_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_param_if
//  Purpose  : Producer/consumer bundle for the parametrised synchronous FIFO.
//             The master modport is the user side, the slave modport is the
//             FIFO itself.
//  Revision : 1.0  initial release
// ============================================================================
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  almost_full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   data_count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  full, almost_full, rd_data, rd_valid, empty, almost_empty,
               data_count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, almost_full, rd_data, rd_valid, empty, almost_empty,
               data_count, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_param
//  Purpose  : Single-clock FIFO, power-of-two depth, optional first-word-
//             fall-through read, almost-full/almost-empty thresholds,
//             occupancy count and sticky overflow/underflow flags.
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 10,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sync_fifo_param_if.slave  fifo_bus
);

    localparam int                  c_DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_FULL   = (ADDR_WIDTH+1)'(c_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_AFULL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] c_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    // Storage is intentionally not reset; pointers alone define contents.
    logic [DATA_WIDTH-1:0] mem_q [c_DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic [ADDR_WIDTH:0] w_count;
    logic                w_full;
    logic                w_empty;
    logic                w_wr_accept;
    logic                w_rd_accept;

    // Occupancy and flags decode straight from the registered pointers.
    assign w_count     = wr_ptr_q - rd_ptr_q;
    assign w_full      = (w_count == c_FULL);
    assign w_empty     = (w_count == '0);
    // Acceptance uses the pre-edge flags, so a read at full never frees the
    // slot for a write in the same cycle.
    assign w_wr_accept = fifo_bus.wr_en && !w_full;
    assign w_rd_accept = fifo_bus.rd_en && !w_empty;

    assign fifo_bus.full         = w_full;
    assign fifo_bus.empty        = w_empty;
    assign fifo_bus.almost_full  = (w_count >= c_AFULL);
    assign fifo_bus.almost_empty = (w_count <= c_AEMPTY);
    assign fifo_bus.data_count   = w_count;
    assign fifo_bus.overflow     = overflow_q;
    assign fifo_bus.underflow    = underflow_q;

    // Next-state for pointers and sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (w_wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (fifo_bus.wr_en && w_full) begin
            overflow_d = 1'b1;
        end
        if (fifo_bus.rd_en && w_empty) begin
            underflow_d = 1'b1;
        end
    end

    // Pointer and flag registers; reset discards all contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Memory write port; reset takes priority over a pending write.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_accept) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= fifo_bus.wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown combinationally; rd_en acknowledges it.
            assign fifo_bus.rd_data  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
            assign fifo_bus.rd_valid = !w_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            // Registered read: one-cycle latency, data held between reads.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= w_rd_accept;
                    if (w_rd_accept) begin
                        rd_data_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
                    end
                end
            end

            assign fifo_bus.rd_data  = rd_data_q;
            assign fifo_bus.rd_valid = rd_valid_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo_param
//  Purpose  : Directed self-checking bench for sync_fifo_param, one instance
//             in registered-read mode and one in first-word-fall-through mode.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sync_fifo_param;

    localparam int c_DW = 8;
    localparam int c_AW = 3;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    sync_fifo_param_if #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW)) if0 ();
    sync_fifo_param_if #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW)) if1 ();

    sync_fifo_param #(
        .DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .FWFT(0),
        .AFULL_THRESH(6), .AEMPTY_THRESH(2)
    ) u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .fifo_bus (if0.slave)
    );

    sync_fifo_param #(
        .DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .FWFT(1),
        .AFULL_THRESH(6), .AEMPTY_THRESH(2)
    ) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .fifo_bus (if1.slave)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        if0.wr_en = 1'b0; if0.rd_en = 1'b0; if0.wr_data = '0;
        if1.wr_en = 1'b0; if1.rd_en = 1'b0; if1.wr_data = '0;

        // ---- Reset state ----
        tick();
        rst = 1'b0;
        chk("rst_count",  16'(if0.data_count),   16'd0);
        chk("rst_empty",  16'(if0.empty),        16'd1);
        chk("rst_full",   16'(if0.full),         16'd0);
        chk("rst_aempty", 16'(if0.almost_empty), 16'd1);
        chk("rst_afull",  16'(if0.almost_full),  16'd0);
        chk("rst_rdv",    16'(if0.rd_valid),     16'd0);
        chk("rst_rdata",  16'(if0.rd_data),      16'd0);
        chk("rst_ovf",    16'(if0.overflow),     16'd0);
        chk("rst_udf",    16'(if0.underflow),    16'd0);
        chk("rst_rdv1",   16'(if1.rd_valid),     16'd0);

        // ---- Fill 0x10..0x17 ----
        for (int i = 0; i < 8; i++) begin
            if0.wr_en = 1'b1; if0.wr_data = 8'(8'h10 + i);
            tick();
            chk("fill_count", 16'(if0.data_count),  16'(i + 1));
            chk("fill_afull", 16'(if0.almost_full), 16'((i + 1) >= 6));
            chk("fill_full",  16'(if0.full),        16'((i + 1) == 8));
            chk("fill_aempt", 16'(if0.almost_empty),16'((i + 1) <= 2));
        end

        // ---- Overflow: write 0xAA while full ----
        if0.wr_data = 8'hAA;
        tick();
        if0.wr_en = 1'b0;
        chk("ovf_flag",  16'(if0.overflow),   16'd1);
        chk("ovf_count", 16'(if0.data_count), 16'd8);

        // ---- Drain: one word per cycle, one cycle after rd_en ----
        for (int i = 0; i < 8; i++) begin
            if0.rd_en = 1'b1;
            tick();
            chk("drain_rdv",   16'(if0.rd_valid),   16'd1);
            chk("drain_data",  16'(if0.rd_data),    16'(8'h10 + i));
            chk("drain_count", 16'(if0.data_count), 16'(7 - i));
            chk("drain_full",  16'(if0.full),       16'd0);
        end
        if0.rd_en = 1'b0;
        tick();
        chk("idle_rdv",   16'(if0.rd_valid), 16'd0);
        chk("idle_hold",  16'(if0.rd_data),  16'h17);
        chk("idle_empty", 16'(if0.empty),    16'd1);

        // ---- Underflow: read the empty FIFO ----
        if0.rd_en = 1'b1;
        tick();
        if0.rd_en = 1'b0;
        chk("udf_flag",  16'(if0.underflow),  16'd1);
        chk("udf_rdv",   16'(if0.rd_valid),   16'd0);
        chk("udf_count", 16'(if0.data_count), 16'd0);
        tick();
        chk("ovf_sticky", 16'(if0.overflow),  16'd1);
        chk("udf_sticky", 16'(if0.underflow), 16'd1);

        // ---- Wrap-around: 20 write-then-read pairs ----
        for (int i = 0; i < 20; i++) begin
            if0.wr_en = 1'b1; if0.wr_data = 8'(i);
            tick();
            if0.wr_en = 1'b0;
            chk("wrap_cnt1", 16'(if0.data_count), 16'd1);
            if0.rd_en = 1'b1;
            tick();
            if0.rd_en = 1'b0;
            chk("wrap_data", 16'(if0.rd_data),    16'(i));
            chk("wrap_cnt0", 16'(if0.data_count), 16'd0);
        end

        // ---- Simultaneous read and write at count 5 ----
        for (int i = 0; i < 5; i++) begin
            if0.wr_en = 1'b1; if0.wr_data = 8'(8'h30 + i);
            tick();
        end
        chk("sim_pre", 16'(if0.data_count), 16'd5);
        for (int k = 0; k < 10; k++) begin
            if0.wr_en = 1'b1; if0.rd_en = 1'b1; if0.wr_data = 8'(8'h35 + k);
            tick();
            chk("sim_count", 16'(if0.data_count), 16'd5);
            chk("sim_data",  16'(if0.rd_data),    16'(8'h30 + k));
            chk("sim_rdv",   16'(if0.rd_valid),   16'd1);
        end
        if0.wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sim_drain", 16'(if0.rd_data), 16'(8'h3A + i));
        end
        if0.rd_en = 1'b0;
        tick();
        chk("sim_empty", 16'(if0.empty), 16'd1);

        // ---- Reset clears sticky flags ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("clr_ovf", 16'(if0.overflow),  16'd0);
        chk("clr_udf", 16'(if0.underflow), 16'd0);

        // ---- Simultaneous read and write at full ----
        for (int i = 0; i < 8; i++) begin
            if0.wr_en = 1'b1; if0.wr_data = 8'(8'h40 + i);
            tick();
        end
        chk("sf_full", 16'(if0.full), 16'd1);
        if0.wr_en = 1'b1; if0.rd_en = 1'b1; if0.wr_data = 8'hBB;
        tick();
        if0.wr_en = 1'b0;
        chk("sf_count", 16'(if0.data_count), 16'd7);
        chk("sf_ovf",   16'(if0.overflow),   16'd1);
        chk("sf_data",  16'(if0.rd_data),    16'h40);
        chk("sf_full2", 16'(if0.full),       16'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("sf_drain", 16'(if0.rd_data), 16'(8'h41 + i));
        end
        if0.rd_en = 1'b0;
        tick();
        chk("sf_empty", 16'(if0.empty), 16'd1);

        // ---- Reset mid-operation ----
        for (int i = 0; i < 4; i++) begin
            if0.wr_en = 1'b1; if0.wr_data = 8'(8'h50 + i);
            tick();
        end
        chk("mr_pre", 16'(if0.data_count), 16'd4);
        if0.wr_en = 1'b1; if0.rd_en = 1'b1; if0.wr_data = 8'h99; rst = 1'b1;
        tick();
        rst = 1'b0; if0.wr_en = 1'b0; if0.rd_en = 1'b0;
        chk("mr_count",  16'(if0.data_count),   16'd0);
        chk("mr_empty",  16'(if0.empty),        16'd1);
        chk("mr_aempty", 16'(if0.almost_empty), 16'd1);
        chk("mr_ovf",    16'(if0.overflow),     16'd0);
        chk("mr_udf",    16'(if0.underflow),    16'd0);
        chk("mr_rdv",    16'(if0.rd_valid),     16'd0);
        chk("mr_rdata",  16'(if0.rd_data),      16'd0);
        if0.wr_en = 1'b1; if0.wr_data = 8'h77;
        tick();
        if0.wr_en = 1'b0; if0.rd_en = 1'b1;
        tick();
        if0.rd_en = 1'b0;
        chk("mr_new",    16'(if0.rd_data),    16'h77);
        chk("mr_newv",   16'(if0.rd_valid),   16'd1);
        chk("mr_newcnt", 16'(if0.data_count), 16'd0);

        // ---- FWFT: word visible the cycle after it is written ----
        chk("fw_empty0", 16'(if1.empty), 16'd1);
        if1.wr_en = 1'b1; if1.wr_data = 8'h5A;
        tick();
        if1.wr_en = 1'b0;
        chk("fw_rdv",   16'(if1.rd_valid),   16'd1);
        chk("fw_data",  16'(if1.rd_data),    16'h5A);
        chk("fw_count", 16'(if1.data_count), 16'd1);
        if1.rd_en = 1'b1;
        tick();
        if1.rd_en = 1'b0;
        chk("fw_pop_empty", 16'(if1.empty),    16'd1);
        chk("fw_pop_rdv",   16'(if1.rd_valid), 16'd0);
        if1.wr_en = 1'b1; if1.wr_data = 8'h11;
        tick();
        if1.wr_data = 8'h22;
        tick();
        if1.wr_en = 1'b0;
        chk("fw_head1", 16'(if1.rd_data), 16'h11);
        tick();
        chk("fw_hold1", 16'(if1.rd_data), 16'h11);
        if1.rd_en = 1'b1;
        tick();
        chk("fw_head2", 16'(if1.rd_data), 16'h22);
        tick();
        if1.rd_en = 1'b0;
        chk("fw_empty2", 16'(if1.empty),     16'd1);
        chk("fw_udf",    16'(if1.underflow), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
